// File: rtl/sram_addr_alloc_pkg.sv
// Shared constants, FSM encoding and range-mask helper for the SRAM address allocator.
package sram_addr_alloc_pkg;

    localparam int ADDR_NUM = 512;
    localparam int AW       = 9;
    localparam int TMO_CYC  = 1023;

    localparam logic [AW:0]     FREE_CNT_RST = (AW+1)'(ADDR_NUM);
    localparam logic [AW+1:0]   ADDR_NUM_X   = (AW+2)'(ADDR_NUM);
    localparam logic [AW+1:0]   TMO_LAST     = (AW+2)'(TMO_CYC - 1);
    localparam logic [AW+1:0]   TMO_STEP     = (AW+2)'(1);
    localparam logic [ADDR_NUM:0] MASK_ONE   = (ADDR_NUM+1)'(1);

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_MASK  = 5'b00010,
        ST_ISSUE = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_RESP  = 5'b10000
    } state_e;

    // One extra bit so len == ADDR_NUM still yields an all-ones mask.
    function automatic logic [ADDR_NUM-1:0] range_mask(input logic [AW-1:0] base,
                                                       input logic [AW:0]   len);
        logic [ADDR_NUM:0] m;
        m = (MASK_ONE << len) - MASK_ONE;
        m = m << base;
        return m[ADDR_NUM-1:0];
    endfunction

endpackage

// File: rtl/sram_range_mask.sv
// Combinational contiguous block-range mask generator.
module sram_range_mask
    import sram_addr_alloc_pkg::*;
(
    input  logic [AW-1:0]       base,
    input  logic [AW:0]         len,
    output logic [ADDR_NUM-1:0] mask
);

    assign mask = range_mask(base, len);

endmodule

// File: rtl/sram_addr_alloc.sv
// Alloc/free request front-end of the SRAM bitmap tracker; one op per tracker rescan.
module sram_addr_alloc
    import sram_addr_alloc_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                alloc_req,
    input  logic [AW:0]         alloc_len,
    output logic                alloc_ack,
    output logic                alloc_ok,
    output logic [AW-1:0]       alloc_addr,
    input  logic                free_req,
    input  logic [AW-1:0]       free_addr,
    input  logic [AW:0]         free_len,
    output logic                free_ack,
    output logic                req_err,
    output logic                wr_start,
    output logic [ADDR_NUM-1:0] wr_use,
    output logic                rd_start,
    output logic [ADDR_NUM-1:0] rd_use,
    input  logic                scan_done,
    input  logic [AW-1:0]       scan_idle_cnt,
    input  logic [AW-1:0]       scan_addr,
    output logic                tmo_err
);

    state_e                state_q, state_d;
    logic                  op_free_q, op_free_d;
    logic [AW-1:0]         base_q, base_d;
    logic [AW:0]           len_q, len_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [ADDR_NUM-1:0]   wr_use_q, wr_use_d;
    logic [ADDR_NUM-1:0]   rd_use_q, rd_use_d;
    logic                  wr_start_q, wr_start_d;
    logic                  rd_start_q, rd_start_d;
    logic                  tmo_err_q, tmo_err_d;
    logic [AW+1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [AW:0]           free_cnt_q, free_cnt_d;
    logic [AW-1:0]         free_base_q, free_base_d;

    logic [ADDR_NUM-1:0]   mask;
    logic [AW+1:0]         free_end;
    logic [AW+1:0]         alloc_end;

    sram_range_mask u_mask (
        .base (base_q),
        .len  (len_q),
        .mask (mask)
    );

    assign free_end  = {2'b00, free_addr}   + {1'b0, free_len};
    assign alloc_end = {2'b00, free_base_q} + {1'b0, alloc_len};

    always_comb begin
        state_d     = state_q;
        op_free_d   = op_free_q;
        base_d      = base_q;
        len_d       = len_q;
        ok_d        = ok_q;
        err_d       = err_q;
        wr_use_d    = wr_use_q;
        rd_use_d    = rd_use_q;
        wr_start_d  = 1'b0;
        rd_start_d  = 1'b0;
        tmo_err_d   = tmo_err_q;
        tmo_cnt_d   = tmo_cnt_q;
        free_cnt_d  = free_cnt_q;
        free_base_d = free_base_q;

        if (scan_done) begin
            free_cnt_d  = {1'b0, scan_idle_cnt};
            free_base_d = scan_addr;
        end

        case (state_q)
            ST_IDLE: begin
                // Free is served first: it can only grow the space an alloc sees.
                if (free_req) begin
                    op_free_d = 1'b1;
                    base_d    = free_addr;
                    len_d     = free_len;
                    ok_d      = 1'b0;
                    if ((free_len == '0) || (free_end > ADDR_NUM_X)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_MASK;
                    end
                end else if (alloc_req) begin
                    op_free_d = 1'b0;
                    base_d    = free_base_q;
                    len_d     = alloc_len;
                    if ((alloc_len == '0) || ({1'b0, alloc_len} > ADDR_NUM_X)) begin
                        ok_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if ((alloc_len <= free_cnt_q) && (alloc_end <= ADDR_NUM_X)) begin
                        ok_d    = 1'b1;
                        err_d   = 1'b0;
                        state_d = ST_MASK;
                    end else begin
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_MASK: begin
                wr_use_d   = op_free_q ? '0 : mask;
                rd_use_d   = op_free_q ? mask : '0;
                wr_start_d = ~op_free_q;
                rd_start_d = op_free_q;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Any scan_done seen here belongs to the previous rescan.
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (scan_done) begin
                    state_d = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    ok_d      = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_STEP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            op_free_q   <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            wr_use_q    <= '0;
            rd_use_q    <= '0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            free_cnt_q  <= FREE_CNT_RST;
            free_base_q <= '0;
        end else begin
            state_q     <= state_d;
            op_free_q   <= op_free_d;
            base_q      <= base_d;
            len_q       <= len_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            wr_use_q    <= wr_use_d;
            rd_use_q    <= rd_use_d;
            wr_start_q  <= wr_start_d;
            rd_start_q  <= rd_start_d;
            tmo_err_q   <= tmo_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
            free_cnt_q  <= free_cnt_d;
            free_base_q <= free_base_d;
        end
    end

    assign alloc_ack  = (state_q == ST_RESP) && !op_free_q;
    assign free_ack   = (state_q == ST_RESP) && op_free_q;
    assign alloc_ok   = alloc_ack && ok_q;
    assign alloc_addr = (alloc_ack && ok_q) ? base_q : '0;
    assign req_err    = (state_q == ST_RESP) && err_q;
    assign wr_start   = wr_start_q;
    assign rd_start   = rd_start_q;
    assign wr_use     = wr_use_q;
    assign rd_use     = rd_use_q;
    assign tmo_err    = tmo_err_q;

endmodule
